div_arbiter: RTL
================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 31, maximum cycles to wait in WAIT for div_res_valid before an error response.
REQ-002 Ports:
  clk  in  1  rising-edge clock.
  rst  in  1  synchronous active-high reset.
  req_valid  in  2  per-requester operation request, bit n = requester n.
  req_ready  out  2  per-requester accept; a transfer occurs when req_valid[n] and req_ready[n] are both high.
  req_sign  in  2  per-requester signed-operation flag.
  req_dividend  in  16  requester n dividend on bits [8n+7:8n].
  req_divisor  in  16  requester n divisor on bits [8n+7:8n].
  rsp_valid  out  2  per-requester result valid.
  rsp_ready  in  2  per-requester result accept.
  rsp_result  out  16  result, shared by both response lanes.
  rsp_err  out  1  error flag for the current response (timeout or divide-by-zero).
  div_opn_valid  out  1  start pulse to the shared radix-2 divider.
  div_sign, div_dividend, div_divisor  out  1/8/8  operands to the divider.
  div_res_valid  in  1  divider done.
  div_result  in  16  divider result {remainder, quotient}.
  busy  out  1  high in every state except IDLE.
REQ-003 Clock is clk; reset is rst, synchronous and active-high. No other clock or reset exists.

Function
REQ-004 FSM states: IDLE, ISSUE, WAIT, RESP; one operation is in flight at a time.
REQ-005 IDLE: if any req_valid bit is high, the arbiter SHALL pick a winner and assert req_ready for the winner only, combinationally, in the same cycle; the loser's req_ready SHALL stay 0.
REQ-006 Arbitration: with a single request, that requester wins; with both requesting, the requester not granted last wins (round-robin). The last-grant pointer updates on each accepted transfer.
REQ-007 On an accepted transfer: latch sign, dividend, divisor and the requester id; move to ISSUE.
REQ-008 ISSUE lasts exactly 1 cycle: div_opn_valid=1 with the latched operands; then move to WAIT. div_opn_valid SHALL be 0 in every other state.
REQ-009 div_sign, div_dividend and div_divisor SHALL hold the latched operands from ISSUE until the FSM leaves WAIT.
REQ-010 WAIT: a cycle counter starts at 0 and increments each cycle. If div_res_valid=1, capture div_result, set err=0 and move to RESP. If the counter reaches TIMEOUT with div_res_valid=0, set result=16'h0000 and err=1, then move to RESP. If both happen in the same cycle, div_res_valid takes priority.
REQ-011 RESP: rsp_valid[id]=1 only; rsp_result and rsp_err are held stable until rsp_ready[id]=1, then return to IDLE in the next cycle. rsp_ready of the other lane is ignored.
REQ-012 div_res_valid is ignored in IDLE, ISSUE and RESP, so a late result after a timeout is discarded.
REQ-013 No request is accepted outside IDLE; req_ready=0 in ISSUE, WAIT and RESP.
REQ-014 Minimum latency from an accepted request to rsp_valid is 2 + D cycles, where D is the number of WAIT cycles.

Reset
REQ-015 On rst=1 at a clock edge, the following SHALL hold on the next cycle:
  state = IDLE
  rsp_valid = 0, rsp_result = 0, rsp_err = 0
  div_opn_valid = 0, div_operands = 0, busy = 0
  last-grant pointer = requester 1, so requester 0 has first priority
  counter = 0
REQ-016 Reset mid-operation (ISSUE, WAIT or RESP) SHALL abandon the operation: no response is produced, and the next divider result is ignored.

Configuration
REQ-017 Macro DIV_ZERO_BYPASS_EN.
  Defined: an accepted request with divisor == 0 skips ISSUE and WAIT and goes directly to RESP with rsp_result=16'hFFFF and rsp_err=1; the divider is not started.
  Undefined: a zero divisor is issued to the divider like any other operand.

Verification
REQ-018 Single request: req0 valid, dividend=8'd100, divisor=8'd7, sign=0; divider model responds after 8 cycles with 16'h020E -> div_opn_valid pulses exactly 1 cycle; rsp_valid[0]=1 with rsp_result=16'h020E, rsp_err=0.
REQ-019 Round-robin: after reset, req0 and req1 both held valid for 4 operations -> grant order is 0,1,0,1; busy stays high from each accepted request through its response handshake.
REQ-020 Timeout: TIMEOUT=31, divider never responds -> after 31 WAIT cycles rsp_valid[n]=1, rsp_result=0, rsp_err=1; a div_res_valid injected later in IDLE produces no response.
REQ-021 Backpressure: hold rsp_ready[1]=0 for 10 cycles during a response to requester 1 -> rsp_result and rsp_err are stable, req_ready=2'b00 throughout, and the FSM returns to IDLE one cycle after rsp_ready[1]=1.
REQ-022 Reset in WAIT: assert rst for 1 cycle -> state returns to IDLE with all outputs at reset values, and the following div_res_valid is ignored.
REQ-023 Zero divisor: divisor=0 -> with DIV_ZERO_BYPASS_EN defined, result=16'hFFFF, err=1, no div_opn_valid pulse; without the macro, div_opn_valid pulses once.

Source files
------------

// File: rtl/div_arbiter.sv
// Two-requester round-robin front end for a shared radix-2 divider.
// Optional DIV_ZERO_BYPASS_EN answers zero-divisor requests without the divider.
module div_arbiter #(
  parameter int TIMEOUT = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_sign,
  input  logic [15:0] req_dividend,
  input  logic [15:0] req_divisor,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [15:0] rsp_result,
  output logic        rsp_err,
  output logic        div_opn_valid,
  output logic        div_sign,
  output logic [7:0]  div_dividend,
  output logic [7:0]  div_divisor,
  input  logic        div_res_valid,
  input  logic [15:0] div_result,
  output logic        busy
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            last;
  logic            id;
  logic            win;
  logic            accept;
  logic            tout;
  logic            sign_q;
  logic [7:0]      dvd_q;
  logic [7:0]      dvs_q;
  logic [15:0]     res_q;
  logic            err_q;
  logic [CW-1:0]   cnt;
  logic            win_sign;
  logic [7:0]      win_dvd;
  logic [7:0]      win_dvs;
`ifdef DIV_ZERO_BYPASS_EN
  logic            zero;
`endif

  // Both requesting: the lane not granted last time wins.
  always_comb begin
    win = 1'b0;
    if (req_valid == 2'b11) win = ~last;
    else if (req_valid[1])  win = 1'b1;
  end

  assign accept   = (state == IDLE) && (|req_valid);
  assign tout     = (cnt == CW'(TIMEOUT - 1));
  assign win_sign = win ? req_sign[1] : req_sign[0];
  assign win_dvd  = win ? req_dividend[15:8] : req_dividend[7:0];
  assign win_dvs  = win ? req_divisor[15:8] : req_divisor[7:0];
`ifdef DIV_ZERO_BYPASS_EN
  assign zero     = (win_dvs == 8'd0);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    div_opn_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef DIV_ZERO_BYPASS_EN
          state_nx = zero ? RESP : ISSUE;
`else
          state_nx = ISSUE;
`endif
        end
      end
      ISSUE: begin
        div_opn_valid = 1'b1;
        state_nx      = WAIT;
      end
      WAIT: begin
        if (div_res_valid || tout) state_nx = RESP;
      end
      RESP: begin
        if (rsp_ready[id]) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last   <= 1'b1;
      id     <= 1'b0;
      sign_q <= 1'b0;
      dvd_q  <= 8'd0;
      dvs_q  <= 8'd0;
      res_q  <= 16'd0;
      err_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
      if (accept) begin
        last   <= win;
        id     <= win;
        sign_q <= win_sign;
        dvd_q  <= win_dvd;
        dvs_q  <= win_dvs;
`ifdef DIV_ZERO_BYPASS_EN
        if (zero) begin
          res_q <= 16'hFFFF;
          err_q <= 1'b1;
        end
`endif
      end
      // A result arriving on the timeout cycle still wins.
      if (state == WAIT) begin
        if (div_res_valid) begin
          res_q <= div_result;
          err_q <= 1'b0;
        end else if (tout) begin
          res_q <= 16'h0000;
          err_q <= 1'b1;
        end
      end
    end
  end

  assign req_ready    = accept ? {win, ~win} : 2'b00;
  assign rsp_valid    = (state == RESP) ? {id, ~id} : 2'b00;
  assign rsp_result   = res_q;
  assign rsp_err      = err_q;
  assign div_sign     = sign_q;
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;
  assign busy         = (state != IDLE);

endmodule
